branch_repair_scheduler: RTL and testbench

- Arbitrates branch-repair requests from the first-stage amend unit (EXE, younger) and the second-stage amend unit (PREMEM, older) against CP0 exception flushes.
- Sequences the accepted repair: one-cycle frontend redirect, then a multi-cycle checkpoint restore to the rename/predictor state.
- Sits between the amend units and the fetch/checkpoint logic; it is the only source of redirects into the frontend.

---
 rtl/branch_repair_scheduler.sv | 163 ++++++++++++++++
 tb/tb_branch_repair_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_repair_scheduler.sv
// branch_repair_scheduler
//   Arbitrates branch-repair requests from the EXE amend unit (FBA, younger)
//   and the PREMEM amend unit (SBA, older) against CP0 exception flushes.
//   Priority is exc > sba > fba. An accepted repair drives a one-cycle
//   frontend redirect followed by a RESTORE_CYCLES-long checkpoint restore.
//   An exception redirect skips the restore.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   fba_req_i/target/ckpt      EXE repair request (level, held until acked)
//   fba_ack_o                  EXE request accepted (IDLE only)
//   sba_req_i/target/ckpt      PREMEM repair request (level, held until acked)
//   sba_ack_o                  PREMEM request accepted (any state)
//   exc_req_i, exc_target_i    CP0 flush pulse and exception vector
//   redirect_valid_o/pc/src    frontend redirect strobe, address, source
//   ckpt_restore_o, ckpt_id_o  checkpoint restore strobe and id
//   frontend_stall_o, busy_o   high whenever a repair sequence is active
module branch_repair_scheduler #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned CKPT_W         = 8,
  parameter int unsigned RESTORE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fba_req_i,
  input  logic [ADDR_W-1:0] fba_target_i,
  input  logic [CKPT_W-1:0] fba_ckpt_i,
  output logic              fba_ack_o,
  input  logic              sba_req_i,
  input  logic [ADDR_W-1:0] sba_target_i,
  input  logic [CKPT_W-1:0] sba_ckpt_i,
  output logic              sba_ack_o,
  input  logic              exc_req_i,
  input  logic [ADDR_W-1:0] exc_target_i,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [1:0]        redirect_src_o,
  output logic              ckpt_restore_o,
  output logic [CKPT_W-1:0] ckpt_id_o,
  output logic              frontend_stall_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REDIR   = 2'd1,
    RESTORE = 2'd2
  } state_t;

  localparam logic [1:0] SRC_FBA = 2'd1;
  localparam logic [1:0] SRC_SBA = 2'd2;
  localparam logic [1:0] SRC_EXC = 2'd3;

  localparam logic [3:0] RESTORE_LOAD = 4'(RESTORE_CYCLES);

  state_t              state, state_next;
  logic [3:0]          cnt, cnt_next;
  logic [ADDR_W-1:0]   target, target_next;
  logic [CKPT_W-1:0]   ckpt, ckpt_next;
  logic [1:0]          src, src_next;
  logic                fba_ack, sba_ack;

  // Acks are combinational so the requester sees acceptance in the same cycle.
  assign sba_ack = sba_req_i & ~exc_req_i;
  assign fba_ack = fba_req_i & ~sba_req_i & ~exc_req_i & (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= '0;
      ckpt   <= '0;
      src    <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      target <= target_next;
      ckpt   <= ckpt_next;
      src    <= src_next;
    end
  end

  // A new accepted event always restarts the sequence at REDIR, aborting
  // whatever was in flight; otherwise the current sequence advances.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    target_next = target;
    ckpt_next   = ckpt;
    src_next    = src;
    if (exc_req_i) begin
      state_next  = REDIR;
      cnt_next    = '0;
      target_next = exc_target_i;
      ckpt_next   = '0;
      src_next    = SRC_EXC;
    end else if (sba_ack) begin
      state_next  = REDIR;
      cnt_next    = '0;
      target_next = sba_target_i;
      ckpt_next   = sba_ckpt_i;
      src_next    = SRC_SBA;
    end else if (fba_ack) begin
      state_next  = REDIR;
      cnt_next    = '0;
      target_next = fba_target_i;
      ckpt_next   = fba_ckpt_i;
      src_next    = SRC_FBA;
    end else begin
      unique case (state)
        IDLE: begin
          state_next = IDLE;
        end
        REDIR: begin
          if (src == SRC_EXC) begin
            state_next = IDLE;
          end else begin
            state_next = RESTORE;
            cnt_next   = RESTORE_LOAD;
          end
        end
        RESTORE: begin
          if (cnt <= 4'd1) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - 4'd1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    fba_ack_o        = fba_ack;
    sba_ack_o        = sba_ack;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    redirect_src_o   = '0;
    ckpt_restore_o   = 1'b0;
    ckpt_id_o        = '0;
    busy_o           = (state != IDLE);
    frontend_stall_o = (state != IDLE);
    unique case (state)
      REDIR: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target;
        redirect_src_o   = src;
      end
      RESTORE: begin
        ckpt_restore_o = 1'b1;
        ckpt_id_o      = ckpt;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_branch_repair_scheduler.sv
module tb_branch_repair_scheduler;

  localparam logic [31:0] T1 = 32'hBFC0_0100;
  localparam logic [7:0]  C1 = 8'h05;
  localparam logic [31:0] T2 = 32'h8000_0040;
  localparam logic [7:0]  C2 = 8'h0A;
  localparam logic [31:0] TE = 32'hBFC0_0380;

  typedef struct {
    logic        fr;  logic [31:0] ft; logic [7:0] fc;
    logic        sr;  logic [31:0] st; logic [7:0] sc;
    logic        er;  logic [31:0] et;
    logic        fa;  logic        sa; logic       rv;
    logic [31:0] pc;  logic [1:0]  src;
    logic        rs;  logic [7:0]  id; logic       busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fba_req, sba_req, exc_req;
  logic [31:0] fba_target, sba_target, exc_target;
  logic [7:0]  fba_ckpt, sba_ckpt;
  logic        fba_ack, sba_ack, redirect_valid, ckpt_restore, frontend_stall, busy;
  logic [31:0] redirect_pc;
  logic [1:0]  redirect_src;
  logic [7:0]  ckpt_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_repair_scheduler #(
    .ADDR_W(32),
    .CKPT_W(8),
    .RESTORE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fba_req_i(fba_req),
    .fba_target_i(fba_target),
    .fba_ckpt_i(fba_ckpt),
    .fba_ack_o(fba_ack),
    .sba_req_i(sba_req),
    .sba_target_i(sba_target),
    .sba_ckpt_i(sba_ckpt),
    .sba_ack_o(sba_ack),
    .exc_req_i(exc_req),
    .exc_target_i(exc_target),
    .redirect_valid_o(redirect_valid),
    .redirect_pc_o(redirect_pc),
    .redirect_src_o(redirect_src),
    .ckpt_restore_o(ckpt_restore),
    .ckpt_id_o(ckpt_id),
    .frontend_stall_o(frontend_stall),
    .busy_o(busy)
  );

  function automatic vec_t mk(
    input logic fr, input logic [31:0] ft, input logic [7:0] fc,
    input logic sr, input logic [31:0] st, input logic [7:0] sc,
    input logic er, input logic [31:0] et,
    input logic fa, input logic sa, input logic rv, input logic [31:0] pc,
    input logic [1:0] src, input logic rs, input logic [7:0] id, input logic busy_e);
    vec_t v;
    v.fr = fr; v.ft = ft; v.fc = fc;
    v.sr = sr; v.st = st; v.sc = sc;
    v.er = er; v.et = et;
    v.fa = fa; v.sa = sa; v.rv = rv; v.pc = pc; v.src = src;
    v.rs = rs; v.id = id; v.busy = busy_e;
    return v;
  endfunction

  // Short-hands: request-only stimulus and output-only expectation.
  function automatic vec_t req(input logic fr, input logic sr, input logic er,
                               input logic fa, input logic sa);
    return mk(fr, T1, C1, sr, T2, C2, er, TE, fa, sa, 1'b0, '0, 2'd0, 1'b0, '0, 1'b0);
  endfunction

  task automatic drive(input vec_t v);
    fba_req = v.fr; fba_target = v.ft; fba_ckpt = v.fc;
    sba_req = v.sr; sba_target = v.st; sba_ckpt = v.sc;
    exc_req = v.er; exc_target = v.et;
  endtask

  task automatic expect_out(input string tag, input vec_t v);
    logic [47:0] act, exp;
    act = {fba_ack, sba_ack, redirect_valid, redirect_pc, redirect_src,
           ckpt_restore, ckpt_id, busy, frontend_stall};
    exp = {v.fa, v.sa, v.rv, v.pc, v.src, v.rs, v.id, v.busy, v.busy};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got fa=%b sa=%b rv=%b pc=%h src=%0d rs=%b id=%h busy=%b stall=%b, want fa=%b sa=%b rv=%b pc=%h src=%0d rs=%b id=%h busy=%b",
               tag, fba_ack, sba_ack, redirect_valid, redirect_pc, redirect_src,
               ckpt_restore, ckpt_id, busy, frontend_stall,
               v.fa, v.sa, v.rv, v.pc, v.src, v.rs, v.id, v.busy);
    end
  endtask

  // Drive just after the rising edge, compare on the falling edge.
  task automatic step(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    expect_out(tag, v);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst = 1'b0;
    drive(req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_out("reset_state", req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;

    // Single FBA, then FBA+SBA together in IDLE.
    tbl.push_back(mk(1, T1, C1, 0, T2, C2, 0, TE, 1, 0, 0, '0, 0, 0, '0, 0));
    tbl.push_back(mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 1, T1, 1, 0, '0, 1));
    tbl.push_back(mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 1, C1, 1));
    tbl.push_back(mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 1, C1, 1));
    tbl.push_back(mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 0, '0, 0));
    tbl.push_back(mk(1, T1, C1, 1, T2, C2, 0, TE, 0, 1, 0, '0, 0, 0, '0, 0));
    tbl.push_back(mk(1, T1, C1, 0, T2, C2, 0, TE, 0, 0, 1, T2, 2, 0, '0, 1));
    tbl.push_back(mk(1, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 1, C2, 1));
    tbl.push_back(mk(1, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 1, C2, 1));
    tbl.push_back(mk(1, T1, C1, 0, T2, C2, 0, TE, 1, 0, 0, '0, 0, 0, '0, 0));
    tbl.push_back(mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 1, T1, 1, 0, '0, 1));
    tbl.push_back(mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 1, C1, 1));
    tbl.push_back(mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 1, C1, 1));
    tbl.push_back(mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 0, '0, 0));
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // SBA arriving in the first FBA restore cycle aborts and restarts.
    step("sba_pre_fba", mk(1, T1, C1, 0, T2, C2, 0, TE, 1, 0, 0, '0, 0, 0, '0, 0));
    step("sba_pre_redir", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 1, T1, 1, 0, '0, 1));
    step("sba_ack_in_restore", mk(0, T1, C1, 1, T2, C2, 0, TE, 0, 1, 0, '0, 0, 1, C1, 1));
    step("sba_redir", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 1, T2, 2, 0, '0, 1));
    step("sba_restore0", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 1, C2, 1));
    step("sba_restore1", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 1, C2, 1));
    step("sba_idle", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 0, '0, 0));

    // Exception with SBA held high during RESTORE.
    step("exs_fba", mk(1, T1, C1, 0, T2, C2, 0, TE, 1, 0, 0, '0, 0, 0, '0, 0));
    step("exs_redir", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 1, T1, 1, 0, '0, 1));
    step("exs_no_acks", mk(0, T1, C1, 1, T2, C2, 1, TE, 0, 0, 0, '0, 0, 1, C1, 1));
    step("exs_exc_redir", mk(0, T1, C1, 1, T2, C2, 0, TE, 0, 1, 1, TE, 3, 0, '0, 1));
    step("exs_sba_redir", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 1, T2, 2, 0, '0, 1));
    step("exs_sba_rest0", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 1, C2, 1));
    step("exs_sba_rest1", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 1, C2, 1));
    step("exs_idle", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 0, '0, 0));

    // Lone exception: redirect then straight to IDLE, no restore.
    step("exc_fba", mk(1, T1, C1, 0, T2, C2, 0, TE, 1, 0, 0, '0, 0, 0, '0, 0));
    step("exc_fredir", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 1, T1, 1, 0, '0, 1));
    step("exc_pulse", mk(0, T1, C1, 0, T2, C2, 1, TE, 0, 0, 0, '0, 0, 1, C1, 1));
    step("exc_redir", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 1, TE, 3, 0, '0, 1));
    step("exc_idle0", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 0, '0, 0));
    step("exc_idle1", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 0, '0, 0, 0, '0, 0));

    // Asynchronous reset in REDIR, then a fresh FBA.
    step("rst_fba", mk(1, T1, C1, 0, T2, C2, 0, TE, 1, 0, 0, '0, 0, 0, '0, 0));
    step("rst_redir", mk(0, T1, C1, 0, T2, C2, 0, TE, 0, 0, 1, T1, 1, 0, '0, 1));
    #1;
    rst = 1'b0;
    #1;
    expect_out("rst_async_clear", req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    expect_out("rst_held", req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    step("post_fba", mk(1, T2, C2, 0, T1, C1, 0, TE, 1, 0, 0, '0, 0, 0, '0, 0));
    step("post_redir", mk(0, T2, C2, 0, T1, C1, 0, TE, 0, 0, 1, T2, 1, 0, '0, 1));
    step("post_rest0", mk(0, T2, C2, 0, T1, C1, 0, TE, 0, 0, 0, '0, 0, 1, C2, 1));
    step("post_rest1", mk(0, T2, C2, 0, T1, C1, 0, TE, 0, 0, 0, '0, 0, 1, C2, 1));
    v = mk(0, T2, C2, 0, T1, C1, 0, TE, 0, 0, 0, '0, 0, 0, '0, 0);
    step("post_idle", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
